// File: rtl/mem_arb_ctrl_if.sv
// Bus bundle for mem_arb_ctrl: two requester ports, their read responses,
// the clear control pair and the single-port memory connection.
//   slave  : controller side (mem_arb_ctrl)
//   master : requester/memory side (environment)
interface mem_arb_ctrl_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned ADDR  = 4
);
    // clear control
    logic             clear_start;
    logic             clear_busy;
    // requester 0
    logic             req0_valid;
    logic             req0_ready;
    logic             req0_we;
    logic [ADDR-1:0]  req0_addr;
    logic [WIDTH-1:0] req0_wdata;
    logic             rsp0_valid;
    logic [WIDTH-1:0] rsp0_rdata;
    // requester 1
    logic             req1_valid;
    logic             req1_ready;
    logic             req1_we;
    logic [ADDR-1:0]  req1_addr;
    logic [WIDTH-1:0] req1_wdata;
    logic             rsp1_valid;
    logic [WIDTH-1:0] rsp1_rdata;
    // memory
    logic             mem_write_en;
    logic [ADDR-1:0]  mem_write_addr;
    logic [WIDTH-1:0] mem_write_data;
    logic [ADDR-1:0]  mem_read_addr;
    logic [WIDTH-1:0] mem_read_data;

    modport slave (
        input  clear_start,
        output clear_busy,
        input  req0_valid, req0_we, req0_addr, req0_wdata,
        output req0_ready, rsp0_valid, rsp0_rdata,
        input  req1_valid, req1_we, req1_addr, req1_wdata,
        output req1_ready, rsp1_valid, rsp1_rdata,
        output mem_write_en, mem_write_addr, mem_write_data, mem_read_addr,
        input  mem_read_data
    );

    modport master (
        output clear_start,
        input  clear_busy,
        output req0_valid, req0_we, req0_addr, req0_wdata,
        input  req0_ready, rsp0_valid, rsp0_rdata,
        output req1_valid, req1_we, req1_addr, req1_wdata,
        input  req1_ready, rsp1_valid, rsp1_rdata,
        input  mem_write_en, mem_write_addr, mem_write_data, mem_read_addr,
        output mem_read_data
    );
endinterface

// File: rtl/mem_arb_ctrl.sv
// Two-requester round-robin controller for a DEPTH x WIDTH memory with
// synchronous write and registered (one-cycle) read. Clears the memory to
// CLEAR_VALUE after reset and on clear_start, then grants one access per cycle.
// Ports:
//   clk    : clock, all state on rising edge
//   rst_n  : synchronous active-low reset
//   bus    : mem_arb_ctrl_if.slave (requests, responses, clear, memory)
module mem_arb_ctrl #(
    parameter int unsigned     WIDTH       = 8,
    parameter int unsigned     DEPTH       = 16,
    parameter int unsigned     ADDR        = $clog2(DEPTH),
    parameter logic [WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arb_ctrl_if.slave bus
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_SERVE = 1'b1
    } state_t;

    state_t           state;
    logic [ADDR-1:0]  clear_cnt;
    logic             rr_ptr;
    logic             rsp0_valid_q;
    logic             rsp1_valid_q;

    logic             gnt0;
    logic             gnt1;
    logic             win_we;
    logic [ADDR-1:0]  win_addr;
    logic [WIDTH-1:0] win_wdata;

    // Round-robin arbitration; rr_ptr only breaks ties.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state == ST_SERVE) begin
            if (bus.req0_valid && (!bus.req1_valid || !rr_ptr)) begin
                gnt0 = 1'b1;
            end else if (bus.req1_valid) begin
                gnt1 = 1'b1;
            end
        end
    end

    // Winner's request fields.
    always_comb begin
        win_we    = 1'b0;
        win_addr  = '0;
        win_wdata = '0;
        if (gnt0) begin
            win_we    = bus.req0_we;
            win_addr  = bus.req0_addr;
            win_wdata = bus.req0_wdata;
        end else if (gnt1) begin
            win_we    = bus.req1_we;
            win_addr  = bus.req1_addr;
            win_wdata = bus.req1_wdata;
        end
    end

    // Memory port drive: clear sweep has priority, otherwise the granted access.
    always_comb begin
        bus.mem_write_en   = 1'b0;
        bus.mem_write_addr = '0;
        bus.mem_write_data = '0;
        bus.mem_read_addr  = '0;
        if (state == ST_CLEAR) begin
            bus.mem_write_en   = 1'b1;
            bus.mem_write_addr = clear_cnt;
            bus.mem_write_data = CLEAR_VALUE;
        end else if ((gnt0 || gnt1) && win_we) begin
            bus.mem_write_en   = 1'b1;
            bus.mem_write_addr = win_addr;
            bus.mem_write_data = win_wdata;
        end else if (gnt0 || gnt1) begin
            bus.mem_read_addr  = win_addr;
        end
    end

    assign bus.req0_ready = gnt0;
    assign bus.req1_ready = gnt1;
    assign bus.clear_busy = (state == ST_CLEAR);
    assign bus.rsp0_valid = rsp0_valid_q;
    assign bus.rsp1_valid = rsp1_valid_q;
    // Memory read data is already registered; route it straight through.
    assign bus.rsp0_rdata = bus.mem_read_data;
    assign bus.rsp1_rdata = bus.mem_read_data;

    // State, clear counter, round-robin pointer and response flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_CLEAR;
            clear_cnt    <= '0;
            rr_ptr       <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
        end else begin
            rsp0_valid_q <= gnt0 && !bus.req0_we;
            rsp1_valid_q <= gnt1 && !bus.req1_we;

            if (gnt0) begin
                rr_ptr <= 1'b1;
            end else if (gnt1) begin
                rr_ptr <= 1'b0;
            end

            if (state == ST_CLEAR) begin
                if (clear_cnt == ADDR'(DEPTH - 1)) begin
                    clear_cnt <= '0;
                    state     <= ST_SERVE;
                end else begin
                    clear_cnt <= clear_cnt + ADDR'(1);
                end
            end else if (bus.clear_start) begin
                state <= ST_CLEAR;
            end
        end
    end

endmodule

// File: tb/tb_mem_arb_ctrl.sv
// Directed bench for mem_arb_ctrl with a registered-read memory model and a
// per-requester response scoreboard.
module tb_mem_arb_ctrl;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned ADDR  = 4;
    localparam logic [WIDTH-1:0] CLR = 8'h00;

    typedef struct {
        int unsigned      cyc;
        logic [WIDTH-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_arb_ctrl_if #(.WIDTH(WIDTH), .ADDR(ADDR)) bus ();

    mem_arb_ctrl #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR(ADDR), .CLEAR_VALUE(CLR)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Memory model: synchronous write, registered read (old data on collision).
    logic [WIDTH-1:0] tb_mem [DEPTH];
    initial for (int i = 0; i < int'(DEPTH); i++) tb_mem[i] = 8'hEE;
    always @(posedge clk) begin
        if (bus.mem_write_en) tb_mem[bus.mem_write_addr] <= bus.mem_write_data;
        bus.mem_read_data <= tb_mem[bus.mem_read_addr];
    end

    int          checks   = 0;
    int          failures = 0;
    int unsigned cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [WIDTH-1:0] ref_mem [DEPTH];
    logic             rr_m = 1'b0;
    exp_t             q0 [$];
    exp_t             q1 [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.clear_start = 1'b0;
        bus.req0_valid = 1'b0; bus.req0_we = 1'b0; bus.req0_addr = '0; bus.req0_wdata = '0;
        bus.req1_valid = 1'b0; bus.req1_we = 1'b0; bus.req1_addr = '0; bus.req1_wdata = '0;
    endtask

    task automatic ref_clear();
        for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = CLR;
    endtask

    // Drive one SERVE-cycle request pattern, check grant and memory port.
    task automatic access(input logic v0, input logic w0, input logic [ADDR-1:0] a0,
                          input logic [WIDTH-1:0] d0,
                          input logic v1, input logic w1, input logic [ADDR-1:0] a1,
                          input logic [WIDTH-1:0] d1, input logic cs);
        int               win;
        logic             ww;
        logic [ADDR-1:0]  wa;
        logic [WIDTH-1:0] wd;
        exp_t             e;
        bus.req0_valid = v0; bus.req0_we = w0; bus.req0_addr = a0; bus.req0_wdata = d0;
        bus.req1_valid = v1; bus.req1_we = w1; bus.req1_addr = a1; bus.req1_wdata = d1;
        bus.clear_start = cs;
        #1;
        win = -1;
        if (v0 && (!v1 || !rr_m)) win = 0;
        else if (v1) win = 1;
        ww = (win == 0) ? w0 : w1;
        wa = (win == 0) ? a0 : a1;
        wd = (win == 0) ? d0 : d1;
        chk("req0_ready", 32'(bus.req0_ready), 32'(win == 0));
        chk("req1_ready", 32'(bus.req1_ready), 32'(win == 1));
        chk("clear_busy_serve", 32'(bus.clear_busy), 32'd0);
        if (win >= 0 && ww) begin
            chk("wr_en", 32'(bus.mem_write_en), 32'd1);
            chk("wr_addr", 32'(bus.mem_write_addr), 32'(wa));
            chk("wr_data", 32'(bus.mem_write_data), 32'(wd));
            chk("rd_addr_on_wr", 32'(bus.mem_read_addr), 32'd0);
            ref_mem[wa] = wd;
        end else begin
            chk("wr_en_idle", 32'(bus.mem_write_en), 32'd0);
            chk("wr_addr_idle", 32'(bus.mem_write_addr), 32'd0);
            chk("wr_data_idle", 32'(bus.mem_write_data), 32'd0);
            chk("rd_addr", 32'(bus.mem_read_addr), (win >= 0) ? 32'(wa) : 32'd0);
            if (win >= 0) begin
                e.cyc = cyc + 1;
                e.data = ref_mem[wa];
                if (win == 0) q0.push_back(e); else q1.push_back(e);
            end
        end
        if (win == 0) rr_m = 1'b1;
        if (win == 1) rr_m = 1'b0;
    endtask

    // Check clear sweep cycles first..last; optionally reset at the last one.
    task automatic clear_cycles(input int first, input int last, input logic rst_last);
        for (int i = first; i <= last; i++) begin
            if (i == int'(DEPTH) - 1) idle();
            #1;
            chk("clear_busy", 32'(bus.clear_busy), 32'd1);
            chk("clear_we", 32'(bus.mem_write_en), 32'd1);
            chk("clear_addr", 32'(bus.mem_write_addr), 32'(i));
            chk("clear_data", 32'(bus.mem_write_data), 32'(CLR));
            chk("clear_ready0", 32'(bus.req0_ready), 32'd0);
            chk("clear_ready1", 32'(bus.req1_ready), 32'd0);
            if (i == last && rst_last) rst_n = 1'b0;
            step();
        end
    endtask

    // Response scoreboard, sampled mid-cycle.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (bus.rsp0_valid) begin
            if (q0.size() == 0) chk("rsp0_valid_unexpected", 32'(bus.rsp0_valid), 32'd0);
            else begin
                e = q0.pop_front();
                chk("rsp0_cycle", cyc, e.cyc);
                chk("rsp0_rdata", 32'(bus.rsp0_rdata), 32'(e.data));
            end
        end else if (q0.size() != 0 && q0[0].cyc <= cyc) begin
            e = q0.pop_front();
            chk("rsp0_valid_missing", 32'(bus.rsp0_valid), 32'd1);
        end
        if (bus.rsp1_valid) begin
            if (q1.size() == 0) chk("rsp1_valid_unexpected", 32'(bus.rsp1_valid), 32'd0);
            else begin
                e = q1.pop_front();
                chk("rsp1_cycle", cyc, e.cyc);
                chk("rsp1_rdata", 32'(bus.rsp1_rdata), 32'(e.data));
            end
        end else if (q1.size() != 0 && q1[0].cyc <= cyc) begin
            e = q1.pop_front();
            chk("rsp1_valid_missing", 32'(bus.rsp1_valid), 32'd1);
        end
    end

    initial begin
        idle();
        ref_clear();
        rst_n = 1'b0;
        repeat (3) step();
        chk("rst_rsp0_valid", 32'(bus.rsp0_valid), 32'd0);
        chk("rst_rsp1_valid", 32'(bus.rsp1_valid), 32'd0);
        chk("rst_clear_busy", 32'(bus.clear_busy), 32'd1);
        chk("rst_clear_addr", 32'(bus.mem_write_addr), 32'd0);

        // 1: initial clear, requests and clear_start ignored, then read all back
        rst_n = 1'b1;
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1; bus.clear_start = 1'b1;
        clear_cycles(0, int'(DEPTH) - 1, 1'b0);
        rr_m = 1'b0;
        ref_clear();
        for (int a = 0; a < int'(DEPTH); a++) begin
            if (a % 2 == 0) access(1'b1, 1'b0, ADDR'(a), 8'h00, 1'b0, 1'b0, '0, 8'h00, 1'b0);
            else            access(1'b0, 1'b0, '0, 8'h00, 1'b1, 1'b0, ADDR'(a), 8'h00, 1'b0);
            step();
        end
        idle(); step();

        // 2: req0 write then read of the same address
        access(1'b1, 1'b1, 4'd3, 8'hA5, 1'b0, 1'b0, '0, 8'h00, 1'b0); step();
        access(1'b1, 1'b0, 4'd3, 8'h00, 1'b0, 1'b0, '0, 8'h00, 1'b0); step();
        idle(); #1;
        chk("t2_rsp1_quiet", 32'(bus.rsp1_valid), 32'd0);
        step(); step();

        // 4: req1 write wins the tie, req0's held read of same address follows
        access(1'b1, 1'b0, 4'd7, 8'h00, 1'b1, 1'b1, 4'd7, 8'h3C, 1'b0); step();
        access(1'b1, 1'b0, 4'd7, 8'h00, 1'b0, 1'b0, '0, 8'h00, 1'b0); step();
        idle(); step(); step();

        // 3: distinct data at 1 and 2, then both read continuously
        access(1'b0, 1'b0, '0, 8'h00, 1'b1, 1'b1, 4'd2, 8'h22, 1'b0); step();
        access(1'b1, 1'b1, 4'd1, 8'h11, 1'b0, 1'b0, '0, 8'h00, 1'b0); step();
        access(1'b0, 1'b0, '0, 8'h00, 1'b1, 1'b0, 4'd2, 8'h00, 1'b0); step();
        repeat (4) begin
            access(1'b1, 1'b0, 4'd1, 8'h00, 1'b1, 1'b0, 4'd2, 8'h00, 1'b0);
            step();
        end
        idle(); step(); step();

        // 5: read granted alongside clear_start returns pre-clear data
        access(1'b1, 1'b1, 4'd15, 8'hFF, 1'b0, 1'b0, '0, 8'h00, 1'b0); step();
        access(1'b1, 1'b0, 4'd15, 8'h00, 1'b0, 1'b0, '0, 8'h00, 1'b1); step();
        bus.clear_start = 1'b0;
        ref_clear();
        clear_cycles(0, int'(DEPTH) - 1, 1'b0);
        access(1'b1, 1'b0, 4'd15, 8'h00, 1'b0, 1'b0, '0, 8'h00, 1'b0); step();
        idle(); step(); step();

        // 6a: reset at clear_cnt == 9 restarts the sweep from 0
        access(1'b0, 1'b0, '0, 8'h00, 1'b0, 1'b0, '0, 8'h00, 1'b1); step();
        idle();
        clear_cycles(0, 9, 1'b1);
        rst_n = 1'b1;
        rr_m = 1'b0;
        clear_cycles(0, int'(DEPTH) - 1, 1'b0);

        // 6b: reset sampled on the edge after a read grant drops the response
        access(1'b1, 1'b1, 4'd4, 8'h5A, 1'b0, 1'b0, '0, 8'h00, 1'b0); step();
        bus.req0_valid = 1'b1; bus.req0_we = 1'b0; bus.req0_addr = 4'd4;
        rst_n = 1'b0;
        #1;
        chk("t6_ready0_pre_rst", 32'(bus.req0_ready), 32'd1);
        step();
        idle();
        rst_n = 1'b1;
        rr_m = 1'b0;
        chk("t6_rsp0_dropped", 32'(bus.rsp0_valid), 32'd0);
        ref_clear();
        clear_cycles(0, int'(DEPTH) - 1, 1'b0);
        access(1'b1, 1'b0, 4'd4, 8'h00, 1'b0, 1'b0, '0, 8'h00, 1'b0); step();
        idle(); step(); step();

        chk("q0_drained", 32'(q0.size()), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arb_ctrl.md
Name: mem_arb_ctrl

Overview:
Two-requester controller that sequences and shares a single synchronous-write, registered-read memory of DEPTH words × WIDTH bits. After reset, and on request, it clears the whole memory to CLEAR_VALUE. It then grants at most one access per cycle, using round-robin arbitration. Read data is returned to the requester that issued the read, one cycle later.

Parameters:
WIDTH, 8, data word width in bits
DEPTH, 16, number of memory words
ADDR, $clog2(DEPTH), address width in bits
CLEAR_VALUE, 0, WIDTH-bit value written to every word during a clear

Ports:
clk  input  1  single clock; all state updates on its rising edge
rst_n  input  1  synchronous, active-low reset
clear_start  input  1  request a full memory clear (sampled only in SERVE)
clear_busy  output  1  high while in CLEAR
req0_valid  input  1  requester 0 access request
req0_ready  output  1  requester 0 granted this cycle
req0_we  input  1  1 = write, 0 = read
req0_addr  input  ADDR  requester 0 address
req0_wdata  input  WIDTH  requester 0 write data
rsp0_valid  output  1  requester 0 read data valid
rsp0_rdata  output  WIDTH  requester 0 read data
req1_valid, req1_ready, req1_we, req1_addr, req1_wdata, rsp1_valid, rsp1_rdata  as for requester 0
mem_write_en  output  1  memory write enable
mem_write_addr  output  ADDR  memory write address
mem_write_data  output  WIDTH  memory write data
mem_read_addr  output  ADDR  memory read address
mem_read_data  input  WIDTH  registered memory read data (one-cycle latency)

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state=CLEAR, clear_cnt=0, rr_ptr=0 (requester 0 preferred).
  - rsp0_valid=rsp1_valid=0.
  - req*_ready=0 while in CLEAR.
- Reset applied mid-clear or mid-transaction restarts the clear from address 0. Any pending read response is dropped.
- States:
  - CLEAR (clear_busy=1):
    - mem_write_en=1, mem_write_addr=clear_cnt, mem_write_data=CLEAR_VALUE.
    - clear_cnt increments each cycle.
    - When clear_cnt==DEPTH-1, next state is SERVE and clear_cnt returns to 0.
    - A clear takes exactly DEPTH cycles.
    - Both ready outputs are 0; clear_start is ignored.
  - SERVE (clear_busy=0):
    - If clear_start=1, next state is CLEAR. Arbitration and grants still occur in that same cycle.
- Arbitration (combinational, SERVE only):
  - Only one valid: that requester is granted.
  - Both valid: the requester indicated by rr_ptr is granted.
  - Neither valid: no grant.
  - reqN_ready = grant to N. A transfer occurs when valid && ready in the same cycle.
  - After any grant to requester N, rr_ptr <= 1-N. With no grant, rr_ptr holds.
- Granted write:
  - mem_write_en=1, mem_write_addr and mem_write_data taken from the winner, all in the same cycle.
  - No response is generated.
- Granted read:
  - mem_read_addr=winner addr in the same cycle.
  - Next cycle: rspN_valid=1 for one cycle (registered flag) and rspN_rdata=mem_read_data (pass-through).
  - There is no response backpressure; requesters must accept.
- Outputs when idle:
  - mem_write_en=0.
  - mem_read_addr=0 when there is no read grant.
  - mem_write_addr and mem_write_data = 0 when not writing.
  - rspN_rdata is don't-care when rspN_valid=0.
- Read-after-write ordering:
  - A write granted in cycle N followed by a read of the same address granted in cycle N+1 returns the new data in cycle N+2.
  - A write and a read cannot be granted in the same cycle.
- Back-to-back reads from alternating requesters sustain one read per cycle. Each response goes only to its own requester.
- A read granted in the cycle that clear_start is accepted still returns its response in the first CLEAR cycle. That response carries pre-clear data.
- Requester inputs must remain stable while valid && !ready. The block does not check this.

Test Plan:
1. Release reset, DEPTH=16 → clear_busy high for exactly 16 cycles, mem_write_addr steps 0..15 with data 0x00; then reading any address returns 0x00.
2. Req0 writes 0xA5 to addr 3, then reads addr 3 → req0_ready=1 on both accesses; rsp0_valid=1 with rsp0_rdata=0xA5 exactly one cycle after the read grant; rsp1_valid stays 0.
3. Both requesters hold valid reads (req0 addr 1, req1 addr 2) for 4 cycles → grants alternate 0,1,0,1; rsp0 and rsp1 alternate, each with its own address's data; no starvation.
4. Req1 writes 0x3C to addr 7 in cycle N while req0 reads addr 7 with valid held → req0 granted in N+1 per round-robin; rsp0_rdata=0x3C in N+2.
5. Write 0xFF to addr 15, then assert clear_start together with a req0 read of addr 15 → read is granted; rsp0 returns 0xFF in the first CLEAR cycle; clear runs 16 cycles with ready=0 throughout; a later read of addr 15 returns 0x00.
6. Drive rst_n=0 for one cycle at clear_cnt=9, and separately one cycle after a read grant → clear restarts at address 0; the pending rsp_valid is suppressed.
